uart_bus_responder: RTL and testbench

// - Bus-side UART responder: the device end of the rdn/wrn/data_ready/tbre/tsre handshake

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_bit_timer.sv | 41 ++++
 rtl/uart_bus_responder.sv | 215 +++++++++++++++++++++
 tb/tb_uart_bus_responder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the bus-side UART responder.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    // Index of the last data bit; the bit counters leave DATA after this one
    localparam logic [2:0] UART_LAST_BIT = 3'(UART_DATA_BITS - 1);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_bit_timer
// Description : Free-running baud counter. full_tick marks the last cycle of
//               a bit period, half_tick the cycle at mid-bit. clear holds the
//               counter at zero so the next bit period starts cleanly.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 96
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic half_tick,
    output logic full_tick
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;

    assign full_tick = (cnt_q == FULL_LAST);
    assign half_tick = (cnt_q == HALF_LAST);

    // Count cycles within a bit, reloading to zero at the end of each bit
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (full_tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : uart_bus_responder
// Description : Device end of the rdn/wrn serial-port handshake. Byte writes
//               are serialised as 8N1 on txd; 8N1 frames on rxd are returned
//               on a read strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bus_responder
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 96
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdn,
    input  logic                      wrn,
    input  logic [UART_DATA_BITS-1:0] data_in,
    output logic [UART_DATA_BITS-1:0] data_out,
    output logic                      data_oe,
    output logic                      data_ready,
    output logic                      tbre,
    output logic                      tsre,
    input  logic                      rxd,
    output logic                      txd
);

    logic rdn_q, wrn_q, data_oe_q;
    logic wr_rise, rd_rise;

    tx_state_t                 tx_state_q;
    logic [UART_DATA_BITS-1:0] hold_q, tx_shift_q;
    logic [2:0]                tx_idx_q;
    logic                      txd_q, tbre_q, tsre_q;
    logic                      tx_full;

    rx_state_t                 rx_state_q;
    logic [UART_DATA_BITS-1:0] rx_shift_q, rx_buf_q;
    logic [2:0]                rx_idx_q;
    logic                      rx_meta_q, rx_s_q, rx_prev_q, data_ready_q;
    logic                      rx_half, rx_full, rx_clear;

    assign wr_rise = wrn & ~wrn_q;
    assign rd_rise = rdn & ~rdn_q;

    assign data_out   = rx_buf_q;
    assign data_oe    = data_oe_q;
    assign data_ready = data_ready_q;
    assign tbre       = tbre_q;
    assign tsre       = tsre_q;
    assign txd        = txd_q;

    // TX bit periods are back-to-back, so only idle needs to hold the counter
    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (tx_state_q == TX_IDLE),
        .half_tick (),
        .full_tick (tx_full)
    );

    // RX realigns to mid-bit once the start bit has been confirmed
    assign rx_clear = (rx_state_q == RX_IDLE) || ((rx_state_q == RX_START) && rx_half);

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (rx_clear),
        .half_tick (rx_half),
        .full_tick (rx_full)
    );

    // Register bus strobes for edge detection and the bus output enable
    always_ff @(posedge clk) begin
        if (rst) begin
            rdn_q     <= 1'b1;
            wrn_q     <= 1'b1;
            data_oe_q <= 1'b0;
        end else begin
            rdn_q     <= rdn;
            wrn_q     <= wrn;
            data_oe_q <= ~rdn;
        end
    end

    // Holding register and TX frame sequencer with registered line output
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            hold_q     <= '0;
            tx_shift_q <= '0;
            tx_idx_q   <= '0;
            txd_q      <= 1'b1;
            tbre_q     <= 1'b1;
            tsre_q     <= 1'b1;
        end else begin
            // Acceptance needs tbre=1; every FSM transfer below needs tbre=0
            if (wr_rise && tbre_q) begin
                hold_q <= data_in;
                tbre_q <= 1'b0;
            end
            case (tx_state_q)
                TX_IDLE: begin
                    if (!tbre_q) begin
                        tx_shift_q <= hold_q;
                        tbre_q     <= 1'b1;
                        tsre_q     <= 1'b0;
                        txd_q      <= 1'b0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_full) begin
                        txd_q      <= tx_shift_q[0];
                        tx_idx_q   <= '0;
                        tx_state_q <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_full) begin
                        if (tx_idx_q == UART_LAST_BIT) begin
                            tx_idx_q   <= '0;
                            txd_q      <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            tx_idx_q <= tx_idx_q + 3'd1;
                            txd_q    <= tx_shift_q[tx_idx_q + 3'd1];
                        end
                    end
                end
                TX_STOP: begin
                    if (tx_full) begin
                        if (!tbre_q) begin
                            // Next byte already waiting: chain frames with no idle gap
                            tx_shift_q <= hold_q;
                            tbre_q     <= 1'b1;
                            txd_q      <= 1'b0;
                            tx_state_q <= TX_START;
                        end else begin
                            tsre_q     <= 1'b1;
                            tx_state_q <= TX_IDLE;
                        end
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    // Two-flop synchroniser for rxd plus previous value for falling-edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rxd;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // RX frame sequencer, receive buffer and data_ready flag
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q   <= RX_IDLE;
            rx_shift_q   <= '0;
            rx_idx_q     <= '0;
            rx_buf_q     <= '0;
            data_ready_q <= 1'b0;
        end else begin
            // Placed first so a byte landing in the same cycle wins
            if (rd_rise) begin
                data_ready_q <= 1'b0;
            end
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_s_q) begin
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_half) begin
                        rx_idx_q   <= '0;
                        rx_state_q <= rx_s_q ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_full) begin
                        rx_shift_q[rx_idx_q] <= rx_s_q;
                        if (rx_idx_q == UART_LAST_BIT) begin
                            rx_idx_q   <= '0;
                            rx_state_q <= RX_STOP;
                        end else begin
                            rx_idx_q <= rx_idx_q + 3'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (rx_full) begin
                        // A low stop bit is a framing error; the byte is dropped
                        if (rx_s_q) begin
                            rx_buf_q     <= rx_shift_q;
                            data_ready_q <= 1'b1;
                        end
                        rx_state_q <= RX_IDLE;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_bus_responder
// Description : Self-checking bench for uart_bus_responder with a timeline
//               model of the transmitter and a byte/flag model of the receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_bus_responder;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst, rdn, wrn, rxd;
    logic [7:0] data_in, data_out;
    logic       data_oe, data_ready, tbre, tsre, txd;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Transmit model: expected bytes and the cycle each frame's start bit begins
    logic [7:0] exp_q[$];
    int         exp_start_q[$];
    int         hold_free = 0;
    int         line_end  = 0;

    // Frames decoded from txd
    logic [7:0] mon_q[$];
    int         mon_start_q[$];
    bit         mon_en = 1'b0;

    // Receive model
    logic [7:0] exp_buf   = 8'h00;
    logic       exp_ready = 1'b0;

    uart_bus_responder #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdn        (rdn),
        .wrn        (wrn),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_oe    (data_oe),
        .data_ready (data_ready),
        .tbre       (tbre),
        .tsre       (tsre),
        .rxd        (rxd),
        .txd        (txd)
    );

    always #5 clk = ~clk;

    // Posedge count: after the k-th rising edge cyc equals k
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // A write edge detected at posedge t is accepted if the holding register
    // is free; its frame starts when both the write has settled and the line
    // has finished the previous frame.
    task automatic model_write(input logic [7:0] b, input int t);
        int s;
        if (t >= hold_free) begin
            s = (t + 1 > line_end) ? t + 1 : line_end;
            exp_q.push_back(b);
            exp_start_q.push_back(s);
            hold_free = s + 1;
            line_end  = s + FRAME;
        end
    endtask

    // Called at a negedge; returns at the negedge where wrn rises
    task automatic bus_write(input logic [7:0] b, input int low_cycles);
        @(negedge clk);
        data_in = b;
        wrn     = 1'b0;
        repeat (low_cycles) @(negedge clk);
        wrn = 1'b1;
        model_write(b, cyc + 1);
    endtask

    task automatic bus_read(input string tag);
        rdn = 1'b0;
        @(negedge clk);
        check({tag, "_oe"}, data_oe, 1'b1);
        check({tag, "_data"}, data_out, exp_buf);
        rdn       = 1'b1;
        exp_ready = 1'b0;
        @(negedge clk);
        check({tag, "_ready_clr"}, data_ready, exp_ready);
        check({tag, "_oe_off"}, data_oe, 1'b0);
    endtask

    // Drive one 8N1 frame on rxd followed by one idle bit time
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (CPB) @(negedge clk);
        if (stop) begin
            exp_buf   = b;
            exp_ready = 1'b1;
        end
    endtask

    // Decode frames on txd by sampling each bit at its middle
    initial begin : tx_monitor
        int         st;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && txd === 1'b0) begin
                st = cyc;
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = txd;
                end
                repeat (CPB) @(negedge clk);
                check("tx_stop_bit", txd, 1'b1);
                mon_q.push_back(b);
                mon_start_q.push_back(st);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [9:0] frame;
        int         n;
        logic [7:0] rb;

        rst = 1'b1; rdn = 1'b1; wrn = 1'b1; rxd = 1'b1; data_in = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_txd", txd, 1'b1);
        check("rst_tbre", tbre, 1'b1);
        check("rst_tsre", tsre, 1'b1);
        check("rst_ready", data_ready, 1'b0);
        check("rst_oe", data_oe, 1'b0);
        check("rst_data_out", data_out, 8'h00);

        // Single write of 0x55: exact line waveform and flag timing
        bus_write(8'h55, 2);
        @(negedge clk);
        check("w55_tbre_low", tbre, 1'b0);
        @(negedge clk);
        check("w55_tbre_back", tbre, 1'b1);
        check("w55_tsre_busy", tsre, 1'b0);
        frame = {1'b1, 8'h55, 1'b0};
        check("w55_bit0", txd, frame[0]);
        for (int i = 1; i < 10; i++) begin
            repeat (CPB) @(negedge clk);
            check($sformatf("w55_bit%0d", i), txd, frame[i]);
        end
        repeat (CPB - 1) @(negedge clk);
        check("w55_tsre_last", tsre, 1'b0);
        @(negedge clk);
        check("w55_tsre_done", tsre, 1'b1);
        check("w55_txd_idle", txd, 1'b1);
        repeat (5) @(negedge clk);

        // Receive 0xA3 and read it back
        send_frame(8'hA3, 1'b1);
        check("rxA3_ready", data_ready, exp_ready);
        bus_read("rxA3");

        // Single-cycle glitch then a framing error
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_ready", data_ready, exp_ready);
        send_frame(8'h3C, 1'b0);
        check("ferr_ready", data_ready, exp_ready);

        // Overrun: second byte overwrites the first
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check("ovr_ready", data_ready, exp_ready);
        bus_read("ovr");

        // Randomized receive traffic with occasional framing errors and reads
        for (int k = 0; k < 10; k++) begin
            rb = 8'($urandom);
            send_frame(rb, ($urandom_range(0, 3) != 0));
            check($sformatf("rnd_rx%0d_ready", k), data_ready, exp_ready);
            if ($urandom_range(0, 1) == 1) bus_read($sformatf("rnd_rx%0d", k));
        end

        // Transmit traffic against the timeline model
        repeat (FRAME + 10) @(negedge clk);
        exp_q.delete();
        exp_start_q.delete();
        mon_en = 1'b1;
        bus_write(8'h01, 1);
        repeat (10) @(negedge clk);
        bus_write(8'h02, 1);
        repeat (2) @(negedge clk);
        bus_write(8'h03, 1);
        repeat (3 * FRAME) @(negedge clk);
        for (int k = 0; k < 14; k++) begin
            repeat ($urandom_range(0, 45)) @(negedge clk);
            bus_write(8'($urandom), 1);
        end
        repeat (4 * FRAME) @(negedge clk);
        mon_en = 1'b0;

        check("tx_frame_count", mon_q.size(), exp_q.size());
        if (mon_start_q.size() >= 2)
            check("b2b_no_gap", mon_start_q[1] - mon_start_q[0], FRAME);
        if (mon_q.size() >= 2) begin
            check("b2b_first", mon_q[0], 8'h01);
            check("b2b_second", mon_q[1], 8'h02);
        end
        n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("tx%0d_byte", i), mon_q[i], exp_q[i]);
            check($sformatf("tx%0d_start", i), mon_start_q[i], exp_start_q[i]);
        end

        // Reset in the middle of a transmit frame
        bus_write(8'hF0, 1);
        repeat (15) @(negedge clk);
        check("pre_rst_busy", tsre, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_txd", txd, 1'b1);
        check("midrst_tbre", tbre, 1'b1);
        check("midrst_tsre", tsre, 1'b1);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
